// File: rtl/button_debouncer.sv
// button_debouncer
//   Debounces one raw pushbutton using a slow sample strobe (tick_in). The raw
//   input passes through a 2-flop synchronizer and an optional polarity fix.
//   A change is accepted only after STABLE_TICKS consecutive agreeing samples.
//   Outputs (all registered, clk_in domain):
//     btn_level      debounced pressed level
//     press_pulse    one-cycle pulse per accepted press (plus auto-repeats)
//     release_pulse  one-cycle pulse per accepted release
//   Optional feature macro: AUTO_REPEAT_EN. When it is defined, extra
//   press_pulse strobes are emitted while the button is held: the first comes
//   REPEAT_DELAY ticks after acceptance, and later ones every REPEAT_RATE ticks.
//   Reset is synchronous and active-high (rst_in). It wins over tick_in.
module button_debouncer #(
  parameter int STABLE_TICKS = 3,
  parameter int ACTIVE_LOW   = 0,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic tick_in,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int                CNT_W    = $clog2(STABLE_TICKS) + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);
  // Raw pin value that means "not pressed"; also the synchronizer reset value.
  localparam logic              RAW_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  // Parameter sanity: reject configurations the qualifier cannot honour.
  if (STABLE_TICKS < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("button_debouncer: STABLE_TICKS must be >= 2, REPEAT_DELAY/RATE >= 1");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync_meta;
  logic             sync_q;
  logic             s;

`ifdef AUTO_REPEAT_EN
  localparam int               REP_W     = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam logic [REP_W-1:0] REP_DELAY = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_WRAP  = REP_W'(REPEAT_DELAY + REPEAT_RATE);

  logic [REP_W-1:0] rep;
  logic [REP_W-1:0] rep_inc;

  assign rep_inc = rep + 1'b1;
`endif

  // Two-flop synchronizer for the asynchronous button, cleared to "not pressed".
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments make sync_q take the previous sync_meta,
    // which gives a true two-stage pipeline; blocking would collapse it to one flop.
    if (rst_in) begin
      sync_meta <= RAW_IDLE;
      sync_q    <= RAW_IDLE;
    end else begin
      sync_meta <= btn_in;
      sync_q    <= sync_meta;
    end
  end

  // Normalised sample: 1 means pressed regardless of pin polarity.
  assign s = sync_q ^ RAW_IDLE;

  // Qualifier FSM with registered level and pulses; advances only on tick_in.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep           <= '0;
`endif
    end else begin
      // Pulses are one cycle wide: cleared every cycle unless set below.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (tick_in) begin
        case (state)
          IDLE: begin
            if (s) begin
              state <= PRESS_WAIT;
              cnt   <= CNT_ONE;
            end
          end
          PRESS_WAIT: begin
            if (!s) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state       <= HELD;
              btn_level   <= 1'b1;
              press_pulse <= 1'b1;
`ifdef AUTO_REPEAT_EN
              rep         <= '0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (!s) begin
              state <= RELEASE_WAIT;
              cnt   <= CNT_ONE;
            end
`ifdef AUTO_REPEAT_EN
            else if (rep_inc == REP_DELAY) begin
              press_pulse <= 1'b1;
              rep         <= rep_inc;
            end else if (rep_inc == REP_WRAP) begin
              // Fold back to the delay point so the period repeats forever.
              press_pulse <= 1'b1;
              rep         <= REP_DELAY;
            end else begin
              rep <= rep_inc;
            end
`endif
          end
          RELEASE_WAIT: begin
            if (s) begin
              // Low glitch rejected: back to HELD silently, level never dropped.
              state <= HELD;
`ifdef AUTO_REPEAT_EN
              rep   <= '0;
`endif
            end else if (cnt == CNT_LAST) begin
              state         <= IDLE;
              cnt           <= '0;
              btn_level     <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
